trellis_index_control: RTL

- Parametrised successor to the single POS transition counter.
- Generates the full nested index sequence for the Viterbi trellis:
  - initial column;
  - forward sweep over word x current POS x previous POS;
  - optional backtrace sweep.
- Sits between the top-level controller and the probability/argmax datapath.
- Adds start/done handshake, stall, runtime sentence length and column-boundary flags.

---
 rtl/viterbi_pkg.sv | 8 +
 rtl/mod_counter.sv | 22 ++
 rtl/trellis_index_control.sv | 82 ++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: sizing defaults and sweep states shared by the trellis index controller
package viterbi_pkg;
    localparam int POS_NUM      = 11;
    localparam int POS_NUM_BIT  = 4;
    localparam int WORD_NUM     = 16;
    localparam int WORD_NUM_BIT = 4;
    typedef enum logic [2:0] {IDLE, INIT, FWD, BACK, DONE} state_t;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: up/down counter that wraps at a runtime limit (up) or at zero (down)
module mod_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         down,
    input  logic [W-1:0] limit,
    output logic [W-1:0] q,
    output logic         wrap
);
    logic [W-1:0] first;
    // clear loads the first value of the chosen direction, so a down sweep starts at limit
    assign first = down ? limit : '0;
    assign wrap  = down ? (q == '0) : (q == limit);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (clr) q <= first;
        else if (en) q <= wrap ? first : (down ? q - W'(1) : q + W'(1));
endmodule

// File: rtl/trellis_index_control.sv
// trellis_index_control: word x cur_pos x prev_pos index sequencer for the Viterbi trellis.
// Define TRELLIS_BACKTRACE_EN to build the backtrace (BACK) sweep; otherwise mode_in is ignored.
module trellis_index_control #(
    parameter int POS_NUM      = viterbi_pkg::POS_NUM,
    parameter int POS_NUM_BIT  = viterbi_pkg::POS_NUM_BIT,
    parameter int WORD_NUM     = viterbi_pkg::WORD_NUM,
    parameter int WORD_NUM_BIT = viterbi_pkg::WORD_NUM_BIT
) (
    input  logic                    clk,
    input  logic                    reset_trellis_index_control,
    input  logic                    start_in,
    input  logic                    mode_in,
    input  logic [WORD_NUM_BIT-1:0] last_word_in,
    input  logic                    stall_in,
    output logic                    busy_out,
    output logic                    valid_out,
    output logic [WORD_NUM_BIT-1:0] word_idx_out,
    output logic [POS_NUM_BIT-1:0]  cur_pos_out,
    output logic [POS_NUM_BIT-1:0]  prev_pos_out,
    output logic                    init_col_out,
    output logic                    col_last_out,
    output logic                    done_out
);
    import viterbi_pkg::*;
    localparam logic [POS_NUM_BIT-1:0] POS_LAST = POS_NUM_BIT'(POS_NUM - 1);
    state_t state;
    logic [WORD_NUM_BIT-1:0] last_q, eff_last, word_lim;
    logic mode_eff, word_down, run, sweep_clr;
    logic prev_en, cur_en, word_en, prev_wrap, cur_wrap, word_wrap;
`ifdef TRELLIS_BACKTRACE_EN
    assign mode_eff  = mode_in;
    assign word_down = state == BACK || (state == IDLE && start_in && mode_in);
`else
    logic unused_mode;
    assign unused_mode = mode_in;
    assign mode_eff    = 1'b0;
    assign word_down   = 1'b0;
`endif
    assign eff_last  = (int'(last_word_in) > WORD_NUM - 1) ? WORD_NUM_BIT'(WORD_NUM - 1) : last_word_in;
    // the word counter needs the new limit in IDLE so a backtrace can preload L
    assign word_lim  = state == IDLE ? eff_last : last_q;
    assign run       = (state == INIT || state == FWD || state == BACK) && !stall_in;
    assign sweep_clr = state == IDLE || state == DONE;
    assign prev_en   = run && state == FWD;
    assign cur_en    = run && (state == INIT || (state == FWD && prev_wrap));
    assign word_en   = run && (state == BACK || (state == INIT && cur_wrap) ||
                               (state == FWD && prev_wrap && cur_wrap));
    mod_counter #(.W(POS_NUM_BIT)) u_prev (
        .clk(clk), .rst_n(reset_trellis_index_control), .en(prev_en), .clr(sweep_clr),
        .down(1'b0), .limit(POS_LAST), .q(prev_pos_out), .wrap(prev_wrap)
    );
    mod_counter #(.W(POS_NUM_BIT)) u_cur (
        .clk(clk), .rst_n(reset_trellis_index_control), .en(cur_en), .clr(sweep_clr),
        .down(1'b0), .limit(POS_LAST), .q(cur_pos_out), .wrap(cur_wrap)
    );
    mod_counter #(.W(WORD_NUM_BIT)) u_word (
        .clk(clk), .rst_n(reset_trellis_index_control), .en(word_en), .clr(sweep_clr),
        .down(word_down), .limit(word_lim), .q(word_idx_out), .wrap(word_wrap)
    );
    always_ff @(posedge clk or negedge reset_trellis_index_control)
        if (!reset_trellis_index_control) begin
            state  <= IDLE;
            last_q <= '0;
        end else
            case (state)
                IDLE: if (start_in) begin
                    last_q <= eff_last;
                    state  <= mode_eff ? BACK : INIT;
                end
                INIT: if (run && cur_wrap) state <= (last_q != '0) ? FWD : DONE;
                FWD:  if (run && prev_wrap && cur_wrap && word_wrap) state <= DONE;
`ifdef TRELLIS_BACKTRACE_EN
                BACK: if (run && word_wrap) state <= DONE;
`endif
                default: state <= IDLE;
            endcase
    assign busy_out     = state != IDLE;
    assign valid_out    = run;
    assign init_col_out = run && state == INIT;
    assign col_last_out = run && (state != FWD || prev_wrap);
    assign done_out     = state == DONE;
endmodule
